// File: rtl/cv32e40x_div_sequencer_pkg.sv
// Shared types and constants for the divider issue/capture sequencer.
// Contents: divider opcode enum, sequencer state enum, trivial-case result
// constants and a signedness helper. No ports.
package cv32e40x_div_sequencer_pkg;

  typedef enum logic [1:0] {
    DIV_DIVU = 2'b00,
    DIV_DIV  = 2'b01,
    DIV_REMU = 2'b10,
    DIV_REM  = 2'b11
  } div_opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_seq_state_e;

  localparam logic [31:0] DIV_BY_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_QUOT     = 32'h8000_0000;

  // Signedness follows the operator alone.
  function automatic logic is_signed_op(div_opcode_e op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

endpackage

// File: rtl/cv32e40x_div_sequencer_if.sv
// Handshake bundle between the sequencer and the serial divider.
// master: sequencer side (drives operands, enable, keep-alive, result ready).
// slave : divider side (drives result valid, ready and result data).
interface cv32e40x_div_sequencer_if;
  import cv32e40x_div_sequencer_pkg::*;

  div_opcode_e div_operator_o;
  logic [31:0] div_op_a_o;
  logic [31:0] div_op_b_o;
  logic        div_data_ind_timing_o;
  logic        div_en_o;
  logic        div_valid_o;
  logic        div_ready_o;
  logic        div_valid_i;
  logic        div_ready_i;
  logic [31:0] div_result_i;

  modport master (
    output div_operator_o, div_op_a_o, div_op_b_o, div_data_ind_timing_o,
           div_en_o, div_valid_o, div_ready_o,
    input  div_valid_i, div_ready_i, div_result_i
  );

  modport slave (
    input  div_operator_o, div_op_a_o, div_op_b_o, div_data_ind_timing_o,
           div_en_o, div_valid_o, div_ready_o,
    output div_valid_i, div_ready_i, div_result_i
  );

endinterface

// File: rtl/cv32e40x_div_trivial_check.sv
// Combinational detector for cases the divider need not compute.
// Ports: operator_i, op_a_i, op_b_i in; hit_o (trivial case found) and
// result_o (architectural result for that case) out.
// Divide-by-zero wins; it can never coincide with signed overflow anyway.
module cv32e40x_div_trivial_check
  import cv32e40x_div_sequencer_pkg::*;
(
  input  div_opcode_e operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        hit_o,
  output logic [31:0] result_o
);

  logic div_zero;
  logic sgn_ovf;
  logic is_rem;

  assign div_zero = (op_b_i == 32'h0);
  assign sgn_ovf  = is_signed_op(operator_i) && (op_a_i == DIV_OVF_QUOT) &&
                    (op_b_i == 32'hFFFF_FFFF);
  assign is_rem   = (operator_i == DIV_REM) || (operator_i == DIV_REMU);
  assign hit_o    = div_zero || sgn_ovf;

  always_comb begin
    result_o = 32'h0;
    if (div_zero) begin
      result_o = is_rem ? op_a_i : DIV_BY_ZERO_QUOT;
    end else if (sgn_ovf) begin
      result_o = is_rem ? 32'h0 : DIV_OVF_QUOT;
    end
  end

endmodule

// File: rtl/cv32e40x_div_sequencer.sv
// Issue/capture stage in front of the serial divider.
// Ports: clk, rst_n (sync, active low); request side operator_i/op_a_i/op_b_i/
// data_ind_timing_i/valid_i/ready_o/kill_i; writeback side valid_o/ready_i/
// result_o; divider side through div_if (master modport).
// Parameter FAST_PATH: 1 resolves divide-by-zero/overflow locally.
// Optional macro CV32E40X_DIV_RESULT_CACHE_EN: remembers the last divider-path
// operation and answers an identical (non constant-time) request from it.
//
// state | meaning
// IDLE  | waiting for a request, ready_o high
// BUSY  | divider running, keep-alive high, result consumed on div_valid_i
// DONE  | result_q presented on valid_o until writeback takes it
module cv32e40x_div_sequencer
  import cv32e40x_div_sequencer_pkg::*;
#(
  parameter bit FAST_PATH = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  div_opcode_e operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        data_ind_timing_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  cv32e40x_div_sequencer_if.master div_if
);

  div_seq_state_e state_q, state_d;
  div_opcode_e    operator_q;
  logic [31:0]    op_a_q, op_b_q, result_q, result_d;
  logic           dit_q;
  logic           load_ops, capture;
  logic           triv_hit, cache_hit, take_fast;
  logic [31:0]    triv_result, cache_result, fast_result;
  logic           unused_div_ready;

  // Divider ready is informational; the keep-alive protocol does not need it.
  assign unused_div_ready = div_if.div_ready_i;

  cv32e40x_div_trivial_check u_trivial_check (
    .operator_i (operator_i),
    .op_a_i     (op_a_i),
    .op_b_i     (op_b_i),
    .hit_o      (triv_hit),
    .result_o   (triv_result)
  );

`ifdef CV32E40X_DIV_RESULT_CACHE_EN
  logic        cache_valid_q;
  div_opcode_e cache_op_q;
  logic [31:0] cache_a_q, cache_b_q, cache_res_q;

  assign cache_hit    = cache_valid_q && !data_ind_timing_i &&
                        (operator_i == cache_op_q) &&
                        (op_a_i == cache_a_q) && (op_b_i == cache_b_q);
  assign cache_result = cache_res_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cache_valid_q <= 1'b0;
      cache_op_q    <= DIV_DIVU;
      cache_a_q     <= 32'h0;
      cache_b_q     <= 32'h0;
      cache_res_q   <= 32'h0;
    end else if (kill_i && (state_q == BUSY)) begin
      cache_valid_q <= 1'b0;
    end else if (capture) begin
      cache_valid_q <= 1'b1;
      cache_op_q    <= operator_q;
      cache_a_q     <= op_a_q;
      cache_b_q     <= op_b_q;
      cache_res_q   <= div_if.div_result_i;
    end
  end
`else
  assign cache_hit    = 1'b0;
  assign cache_result = 32'h0;
`endif

  assign take_fast   = (FAST_PATH && triv_hit && !data_ind_timing_i) || cache_hit;
  assign fast_result = (FAST_PATH && triv_hit) ? triv_result : cache_result;

  always_comb begin
    state_d            = state_q;
    result_d           = result_q;
    ready_o            = 1'b0;
    valid_o            = 1'b0;
    load_ops           = 1'b0;
    capture            = 1'b0;
    div_if.div_valid_o = 1'b0;
    div_if.div_ready_o = 1'b0;
    div_if.div_en_o    = (state_q == BUSY);

    if (kill_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: ready_o = 1'b1;
        BUSY: begin
          div_if.div_valid_o = 1'b1;
          div_if.div_ready_o = 1'b1;
          if (div_if.div_valid_i) begin
            result_d = div_if.div_result_i;
            capture  = 1'b1;
            state_d  = DONE;
          end
        end
        DONE: begin
          valid_o = 1'b1;
          if (ready_i) begin
            ready_o = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      // Accept is shared by IDLE and the draining DONE cycle.
      if (ready_o && valid_i) begin
        load_ops = 1'b1;
        if (take_fast) begin
          result_d = fast_result;
          state_d  = DONE;
        end else begin
          state_d  = BUSY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      operator_q <= DIV_DIVU;
      op_a_q     <= 32'h0;
      op_b_q     <= 32'h0;
      dit_q      <= 1'b0;
      result_q   <= 32'h0;
    end else begin
      result_q <= result_d;
      if (load_ops) begin
        operator_q <= operator_i;
        op_a_q     <= op_a_i;
        op_b_q     <= op_b_i;
        dit_q      <= data_ind_timing_i;
      end
    end
  end

  assign result_o                     = result_q;
  assign div_if.div_operator_o        = operator_q;
  assign div_if.div_op_a_o            = op_a_q;
  assign div_if.div_op_b_o            = op_b_q;
  assign div_if.div_data_ind_timing_o = dit_q;

endmodule

// File: tb/tb_cv32e40x_div_sequencer.sv
// Scoreboard bench for cv32e40x_div_sequencer. The driver pushes the expected
// result and path (local or divider) at every accept; a monitor pops and
// checks on each writeback handshake. A behavioural divider answers requests
// after a programmable latency. Cache checks exist when
// CV32E40X_DIV_RESULT_CACHE_EN is defined.
module tb_cv32e40x_div_sequencer;
  import cv32e40x_div_sequencer_pkg::*;

  localparam bit FAST_PATH = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  div_opcode_e operator_i;
  logic [31:0] op_a_i, op_b_i;
  logic        data_ind_timing_i, valid_i, kill_i, ready_i;
  logic        ready_o, valid_o;
  logic [31:0] result_o;

  cv32e40x_div_sequencer_if dif();

  cv32e40x_div_sequencer #(.FAST_PATH(FAST_PATH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .operator_i        (operator_i),
    .op_a_i            (op_a_i),
    .op_b_i            (op_b_i),
    .data_ind_timing_i (data_ind_timing_i),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .kill_i            (kill_i),
    .valid_o           (valid_o),
    .ready_i           (ready_i),
    .result_o          (result_o),
    .div_if            (dif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    bit          fast;
    int          acc_cyc;
  } exp_t;
  exp_t exp_q[$];

  int  div_lat = 3;
  int  sink_mode = 2;   // 0 random, 1 hold low, 2 always accept
  bit  acc_valid_o;     // valid_o seen in the accept cycle of the last send

  bit          c_valid = 1'b0;
  div_opcode_e c_op = DIV_DIVU;
  logic [31:0] c_a = 32'h0, c_b = 32'h0;

  // RISC-V M-extension semantics using 64-bit arithmetic.
  function automatic logic [31:0] ref_div(div_opcode_e op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (b == 32'h0) return (op == DIV_DIV || op == DIV_DIVU) ? 32'hFFFF_FFFF : a;
    case (op)
      DIV_DIVU: return 32'(ua / ub);
      DIV_REMU: return 32'(ua % ub);
      DIV_DIV:  return 32'(sa / sb);
      default:  return 32'(sa % sb);
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural divider: answers after div_lat cycles of keep-alive.
  initial begin
    int cnt = 0;
    dif.div_valid_i  = 1'b0;
    dif.div_ready_i  = 1'b1;
    dif.div_result_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      dif.div_valid_i = 1'b0;
      if (dif.div_valid_o) begin
        cnt++;
        if (cnt >= div_lat) begin
          dif.div_valid_i  = 1'b1;
          dif.div_result_i = ref_div(dif.div_operator_o, dif.div_op_a_o, dif.div_op_b_o);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Writeback sink.
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (sink_mode)
        0:       ready_i = ($urandom_range(0, 3) != 0);
        1:       ready_i = 1'b0;
        default: ready_i = 1'b1;
      endcase
    end
  end

  // Monitor.
  initial begin
    bit          pend = 1'b0;
    bit          div_used = 1'b0;
    int          cap_cyc = 0;
    logic [31:0] held = 32'h0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n || kill_i) begin
        pend = 1'b0;
        div_used = 1'b0;
      end else begin
        if (dif.div_valid_o) div_used = 1'b1;
        if (dif.div_valid_i && dif.div_ready_o) cap_cyc = cyc + 1;
        if (valid_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got valid_o=1 required no result, result_o=%h", result_o);
          end else begin
            e = exp_q[0];
            if (pend) begin
              check("latency", 32'(cyc), 32'(e.fast ? e.acc_cyc : cap_cyc));
              check("divider_used", 32'(div_used), 32'(!e.fast));
            end else begin
              check("hold_stable", result_o, held);
            end
            held = result_o;
            pend = 1'b0;
            if (ready_i) begin
              void'(exp_q.pop_front());
              check("result", result_o, e.res);
            end
          end
        end
        if (valid_i && ready_o) begin
          pend = 1'b1;
          div_used = 1'b0;
        end
      end
    end
  end

  // Caller must be just after a rising edge; returns just after the accept edge.
  task automatic send(div_opcode_e op, logic [31:0] a, logic [31:0] b, logic dit);
    exp_t e;
    bit   fast;
    int   n = 0;
    bit   ok = 1'b1;
    operator_i = op; op_a_i = a; op_b_i = b; data_ind_timing_i = dit; valid_i = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_o) break;
      n++;
      if (n > 300) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got ready_o=0 for %0d cycles required accept", n);
        ok = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      acc_valid_o = valid_o;
      fast = FAST_PATH && !dit && ((b == 32'h0) ||
             ((op == DIV_DIV || op == DIV_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef CV32E40X_DIV_RESULT_CACHE_EN
      if (c_valid && !dit && op == c_op && a == c_a && b == c_b) fast = 1'b1;
      if (!fast) begin
        c_valid = 1'b1; c_op = op; c_a = a; c_b = b;
      end
`endif
      e.res = ref_div(op, a, b);
      e.fast = fast;
      e.acc_cyc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    op_a_i = $urandom;
    op_b_i = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending results required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Called just after the accept edge of a long divider op.
  task automatic kill_in_busy();
    @(posedge clk); #1;
    @(posedge clk); #1;
    kill_i = 1'b1;
    void'(exp_q.pop_back());
    c_valid = 1'b0;
    @(negedge clk);
    check("kill_div_valid", 32'(dif.div_valid_o), 32'h0);
    check("kill_valid_o", 32'(valid_o), 32'h0);
    check("kill_ready_o", 32'(ready_o), 32'h0);
    @(posedge clk); #1;
    kill_i = 1'b0;
    @(negedge clk);
    check("post_kill_ready", 32'(ready_o), 32'h1);
    check("post_kill_div_en", 32'(dif.div_en_o), 32'h0);
    check("post_kill_valid_o", 32'(valid_o), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required completion");
    $fatal(1);
  end

  initial begin
    int          n;
    div_opcode_e op, last_op;
    logic [31:0] a, b, last_a, last_b;
    logic        d;
    last_op = DIV_DIVU; last_a = 32'd1; last_b = 32'd1;
    rst_n = 1'b0; valid_i = 1'b0; kill_i = 1'b0; operator_i = DIV_DIVU;
    op_a_i = 32'h0; op_b_i = 32'h0; data_ind_timing_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_o", 32'(valid_o), 32'h0);
    check("rst_div_valid", 32'(dif.div_valid_o), 32'h0);
    check("rst_div_en", 32'(dif.div_en_o), 32'h0);
    check("rst_div_ready", 32'(dif.div_ready_o), 32'h0);
    check("rst_result", result_o, 32'h0);
    check("rst_op_a", dif.div_op_a_o, 32'h0);
    check("rst_op_b", dif.div_op_b_o, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_o", 32'(ready_o), 32'h1);
    @(posedge clk); #1;

    send(DIV_DIVU, 32'd100, 32'd0, 1'b0);
    send(DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    div_lat = 2;
    send(DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    div_lat = 4;
    send(DIV_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    drain();

    // Hold writeback off for five DONE cycles, then accept back-to-back.
    sink_mode = 1;
    div_lat = 2;
    send(DIV_DIVU, 32'd50, 32'd7, 1'b0);
    n = 0;
    while (!valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached_done", 32'(valid_o), 32'h1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    sink_mode = 2;
    send(DIV_REMU, 32'd77, 32'd5, 1'b0);
    check("b2b_accept_in_done", 32'(acc_valid_o), 32'h1);
    drain();

    div_lat = 10;
    send(DIV_DIV, 32'd1234, 32'd5, 1'b0);
    kill_in_busy();
    div_lat = 3;
    send(DIV_REMU, 32'd10, 32'd3, 1'b0);
    drain();

    // Reset in the middle of a divider operation drops it.
    div_lat = 10;
    send(DIV_DIVU, 32'd999, 32'd4, 1'b0);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    c_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid_o", 32'(valid_o), 32'h0);
    check("midrst_div_valid", 32'(dif.div_valid_o), 32'h0);
    check("midrst_ready_o", 32'(ready_o), 32'h1);
    check("midrst_result", result_o, 32'h0);
    @(posedge clk); #1;

`ifdef CV32E40X_DIV_RESULT_CACHE_EN
    div_lat = 4;
    send(DIV_DIVU, 32'd1000, 32'd7, 1'b0);
    send(DIV_DIVU, 32'd1000, 32'd7, 1'b0);
    drain();
    div_lat = 10;
    send(DIV_DIVU, 32'd5000, 32'd3, 1'b0);
    kill_in_busy();
    div_lat = 3;
    send(DIV_DIVU, 32'd1000, 32'd7, 1'b0);
    drain();
`endif

    sink_mode = 0;
    repeat (60) begin
      if ($urandom_range(0, 4) == 0) begin
        op = last_op; a = last_a; b = last_b;
      end else begin
        op = div_opcode_e'($urandom_range(0, 3));
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 5))
          0: b = 32'h0;
          1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
          2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 13); end
          default: ;
        endcase
      end
      d = ($urandom_range(0, 3) == 0);
      div_lat = $urandom_range(1, 5);
      send(op, a, b, d);
      last_op = op; last_a = a; last_b = b;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
